mult_div_sequencer: RTL and testbench

Multi-cycle multiply/divide responder that owns the architectural HI/LO pair. The execute stage initiates MULT/MULTU/DIV/DIVU with a start pulse plus operands, and observes busy/done. The block iterates one bit per cycle (shift-add multiply, restoring divide) and publishes HI/LO once complete. HI/LO outputs feed the execute-stage result mux for MFHI/MFLO.

---
 rtl/mult_div_sequencer_if.sv | 14 +
 rtl/mult_div_sequencer.sv | 98 +++++++++
 tb/tb_mult_div_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_sequencer_if.sv
// mult_div_sequencer_if: execute-stage request/response bundle for the multiply/divide sequencer.
interface mult_div_sequencer_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             busy;
    logic             done;
    logic             divByZero;
    logic [WIDTH-1:0] hiOut;
    logic [WIDTH-1:0] loOut;
    modport master(output start, op, operandA, operandB, input busy, done, divByZero, hiOut, loOut);
    modport slave(input start, op, operandA, operandB, output busy, done, divByZero, hiOut, loOut);
endinterface

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: bit-serial MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Define MDU_EARLY_OUT_EN to let multiplies stop once the remaining multiplier is zero.
module mult_div_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic clk,
    input logic reset,
    mult_div_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t             state;
    logic               is_div, sa, sb, busy, done, dbz;
    logic [2*WIDTH-1:0] acc, mc;
    logic [WIDTH-1:0]   mr, a_raw, hi, lo;
    logic [CNT_W-1:0]   cnt;
    logic               sgn, ge, last;
    logic [WIDTH-1:0]   a_mag, b_mag, q, r;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    always_comb begin
        sgn = !bus.op[0];
        a_mag = (sgn && bus.operandA[WIDTH-1]) ? -bus.operandA : bus.operandA;
        b_mag = (sgn && bus.operandB[WIDTH-1]) ? -bus.operandB : bus.operandB;
        mul_next = acc + (mr[0] ? mc : '0);
        // restoring step: the shifted-out top bit means the partial remainder already exceeds the divisor
        ge = acc[2*WIDTH-1] || (acc[2*WIDTH-2:WIDTH-1] >= mr);
        div_next = {ge ? acc[2*WIDTH-2:WIDTH-1] - mr : acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], ge};
        prod = (sa ^ sb) ? -acc : acc;
        q = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`ifdef MDU_EARLY_OUT_EN
        last = (cnt == '0) || (!is_div && mr[WIDTH-1:1] == '0);
`else
        last = (cnt == '0);
`endif
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            is_div <= 1'b0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dbz    <= 1'b0;
            acc    <= '0;
            mc     <= '0;
            mr     <= '0;
            a_raw  <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            dbz  <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    is_div <= bus.op[1];
                    sa     <= sgn && bus.operandA[WIDTH-1];
                    sb     <= sgn && bus.operandB[WIDTH-1];
                    a_raw  <= bus.operandA;
                    acc    <= bus.op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
                    mc     <= {{WIDTH{1'b0}}, a_mag};
                    mr     <= b_mag;
                    cnt    <= CNT_W'(WIDTH - 1);
                    busy   <= 1'b1;
                    state  <= CALC;
                end
                CALC: begin
                    if (is_div) acc <= div_next;
                    else begin
                        acc <= mul_next;
                        mc  <= mc << 1;
                        mr  <= mr >> 1;
                    end
                    cnt <= cnt - 1'b1;
                    if (last) state <= FIX;
                end
                FIX: begin
                    hi    <= !is_div ? prod[2*WIDTH-1:WIDTH] : (mr == '0) ? a_raw : r;
                    lo    <= !is_div ? prod[WIDTH-1:0] : (mr == '0) ? '1 : q;
                    dbz   <= is_div && mr == '0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.divByZero = dbz;
    assign bus.hiOut     = hi;
    assign bus.loOut     = lo;
endmodule

// File: tb/tb_mult_div_sequencer.sv
// tb_mult_div_sequencer: randomized and directed checks of the multiply/divide sequencer against an arithmetic model.
module tb_mult_div_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    mult_div_sequencer_if #(.WIDTH(32)) bus();
    mult_div_sequencer #(.WIDTH(32), .CNT_W(6)) dut(.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dz, output int lat);
        longint sp;
        logic [63:0] up;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin sp = longint'($signed(a)) * longint'($signed(b)); {hi, lo} = sp; end
            2'b01: begin up = {32'b0, a} * {32'b0, b}; {hi, lo} = up; end
            default: if (b == 0) begin hi = a; lo = '1; dz = 1'b1; end
            else if (op == 2'b10) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = a; hi = '0; end
                else begin lo = $signed(a) / $signed(b); hi = $signed(a) % $signed(b); end
            end else begin lo = a / b; hi = a % b; end
        endcase
        lat = 33;
`ifdef MDU_EARLY_OUT_EN
        if (!op[1]) begin
            logic [31:0] bm;
            int msb;
            bm = (op == 2'b00 && b[31]) ? -b : b;
            msb = 0;
            for (int i = 0; i < 32; i++) if (bm[i]) msb = i + 1;
            lat = (msb < 1 ? 1 : msb) + 1;
        end
`endif
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] hi_e, lo_e;
        logic dz_e;
        int lat_e, n;
        bit got;
        model(op, a, b, hi_e, lo_e, dz_e, lat_e);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.operandA = a; bus.operandB = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0; bus.op = 2'($urandom); bus.operandA = $urandom; bus.operandB = $urandom;
        checks++;
        if (bus.busy !== 1'b1) begin failures++; $display("FAIL busy_after_start op=%0d got %b expected 1", op, bus.busy); end
        n = 0; got = 0;
        while (n < 40 && !got) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (bus.done) got = 1;
        end
        checks++;
        if (!got || n != lat_e) begin failures++; $display("FAIL latency op=%0d a=%h b=%h got %0d expected %0d", op, a, b, got ? n : -1, lat_e); end
        checks += 3;
        if (bus.hiOut !== hi_e) begin failures++; $display("FAIL hi op=%0d a=%h b=%h got %h expected %h", op, a, b, bus.hiOut, hi_e); end
        if (bus.loOut !== lo_e) begin failures++; $display("FAIL lo op=%0d a=%h b=%h got %h expected %h", op, a, b, bus.loOut, lo_e); end
        if (bus.divByZero !== dz_e) begin failures++; $display("FAIL div_by_zero op=%0d got %b expected %b", op, bus.divByZero, dz_e); end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL idle_after_done busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    endtask

    task automatic test_reset;
        bus.start = 1'b0; bus.op = 2'b00; bus.operandA = '0; bus.operandB = '0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b expected 0", bus.done); end
        if (bus.divByZero !== 1'b0) begin failures++; $display("FAIL reset_dbz got %b expected 0", bus.divByZero); end
        if (bus.hiOut !== 32'h0) begin failures++; $display("FAIL reset_hi got %h expected 0", bus.hiOut); end
        if (bus.loOut !== 32'h0) begin failures++; $display("FAIL reset_lo got %h expected 0", bus.loOut); end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b11, 32'd7, 32'd2);
        run_op(2'b11, 32'h0000_1234, 32'd0);
        run_op(2'b10, 32'h8000_0007, 32'd0);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE);
    endtask

    task automatic test_ignored_start;
        int dones = 0, first = -1;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.operandA = 32'h8000_0000; bus.operandB = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            bus.start = (e == 5);
            @(posedge clk);
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (first < 0) first = e;
                checks += 2;
                if (bus.loOut !== 32'h8000_0000) begin failures++; $display("FAIL ovf_lo got %h expected 80000000", bus.loOut); end
                if (bus.hiOut !== 32'h0) begin failures++; $display("FAIL ovf_hi got %h expected 0", bus.hiOut); end
            end
        end
        checks += 2;
        if (dones != 1) begin failures++; $display("FAIL ignored_start_dones got %0d expected 1", dones); end
        if (first != 33) begin failures++; $display("FAIL ignored_start_latency got %0d expected 33", first); end
    endtask

    task automatic test_back_to_back;
        int seen[$];
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.operandA = 32'd100; bus.operandB = 32'd7;
        @(posedge clk);
        for (int e = 1; e <= 75; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                seen.push_back(e);
                checks += 2;
                if (bus.loOut !== 32'd14) begin failures++; $display("FAIL hold_lo got %h expected e", bus.loOut); end
                if (bus.hiOut !== 32'd2) begin failures++; $display("FAIL hold_hi got %h expected 2", bus.hiOut); end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (seen.size() != 2 || seen[0] != 33 || seen[1] != 68) begin
            failures++;
            $display("FAIL hold_done_edges got n=%0d first=%0d second=%0d expected 2 33 68",
                     seen.size(), seen.size() > 0 ? seen[0] : -1, seen.size() > 1 ? seen[1] : -1);
        end
        n = 0;
        while (bus.busy && n < 60) begin @(negedge clk); n++; end
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL hold_drain busy got %b expected 0", bus.busy); end
    endtask

    task automatic test_random;
        logic [1:0] op;
        logic [31:0] a, b;
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op(op, a, b);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.operandA = 32'd5; bus.operandB = 32'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks += 4;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin failures++; $display("FAIL midreset_done got %b expected 0", bus.done); end
        if (bus.hiOut !== 32'h0) begin failures++; $display("FAIL midreset_hi got %h expected 0", bus.hiOut); end
        if (bus.loOut !== 32'h0) begin failures++; $display("FAIL midreset_lo got %h expected 0", bus.loOut); end
        @(negedge clk);
        reset = 1'b0;
        run_op(2'b01, 32'd3, 32'd5);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
